// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared types and helpers for the LED pattern engine.
package led_seq_pkg;
  typedef enum logic [1:0] {
    ROTATE_L = 2'd0,
    ROTATE_R = 2'd1,
    BOUNCE   = 2'd2,
    BAR      = 2'd3
  } led_mode_t;
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;
  function automatic logic [31:0] bar_mask(input logic [31:0] count);
    return (count >= 32) ? '1 : ((32'd1 << count) - 32'd1);
  endfunction
endpackage

// File: rtl/led_strobe_gen.sv
// led_strobe_gen: free-running prescaler; registered carry gives a one-cycle strobe every 2^COUNTER_WIDTH running cycles.
module led_strobe_gen #(
  parameter int COUNTER_WIDTH = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic clr_i,
  output logic stb_o
);
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d, sum;
  logic                     stb_q, stb_d, carry;
  assign {carry, sum} = {1'b0, cnt_q} + {{COUNTER_WIDTH{1'b0}}, 1'b1};
  always_comb begin
    cnt_d = clr_i ? '0 : run_i ? sum : cnt_q;
    stb_d = !clr_i && run_i && carry;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      stb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      stb_q <= stb_d;
    end
  end
  assign stb_o = stb_q;
endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: prescaled LED pattern engine (rotate left/right, bounce, bar); optional PWM dimming via LED_SEQ_PWM_EN.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int                   COUNTER_WIDTH = 25,
  parameter int                   LED_COUNT     = 4,
  parameter logic [LED_COUNT-1:0] SEED          = {{(LED_COUNT-1){1'b0}}, 1'b1}
`ifdef LED_SEQ_PWM_EN
  , parameter int                 PWM_WIDTH     = 4
`endif
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_run,
  input  logic                 i_step,
  input  logic [1:0]           i_mode,
`ifdef LED_SEQ_PWM_EN
  input  logic [PWM_WIDTH-1:0] i_duty,
`endif
  output logic [LED_COUNT-1:0] o_led,
  output logic                 o_stb
);
  localparam int PW = $clog2(LED_COUNT);
  localparam int CW = $clog2(LED_COUNT + 1);
  localparam logic [PW-1:0]        POS_MAX = PW'(LED_COUNT - 1);
  localparam logic [CW-1:0]        CNT_MAX = CW'(LED_COUNT);
  localparam logic [LED_COUNT-1:0] ONE     = LED_COUNT'(1);
  led_mode_t            mode_q, mode_d, mode_in;
  dir_t                 dir_q, dir_d;
  logic [PW-1:0]        pos_q, pos_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [LED_COUNT-1:0] led_q, led_d;
  logic                 stb_q, stb_d, pre_stb, adv, mode_chg, turn;
  assign mode_in  = led_mode_t'(i_mode);
  assign mode_chg = mode_q != mode_in;
  assign adv      = pre_stb | i_step;
  led_strobe_gen #(
    .COUNTER_WIDTH(COUNTER_WIDTH)
  ) u_strobe (
    .clk  (i_clk),
    .rst  (i_reset),
    .run_i(i_run),
    .clr_i(mode_chg),
    .stb_o(pre_stb)
  );
  // Bounce reverses at either end so no end LED is shown twice in a row.
  assign turn = (dir_q == DIR_UP) ? (pos_q == POS_MAX) : (pos_q == '0);
  always_comb begin
    mode_d = mode_q;
    dir_d  = dir_q;
    pos_d  = pos_q;
    cnt_d  = cnt_q;
    led_d  = led_q;
    stb_d  = 1'b0;
    if (mode_chg) begin
      mode_d = mode_in;
      dir_d  = DIR_UP;
      pos_d  = '0;
      cnt_d  = '0;
      led_d  = (mode_in == BOUNCE) ? ONE : (mode_in == BAR) ? '0 : SEED;
    end else if (adv) begin
      stb_d = 1'b1;
      dir_d = (mode_q == BOUNCE && turn) ? dir_t'(~dir_q) : dir_q;
      pos_d = (mode_q != BOUNCE) ? pos_q : (dir_d == DIR_UP) ? pos_q + PW'(1) : pos_q - PW'(1);
      cnt_d = (mode_q != BAR) ? cnt_q : (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
      led_d = (mode_q == ROTATE_L) ? {led_q[LED_COUNT-2:0], led_q[LED_COUNT-1]}
            : (mode_q == ROTATE_R) ? {led_q[0], led_q[LED_COUNT-1:1]}
            : (mode_q == BOUNCE)   ? ONE << pos_d
            : LED_COUNT'(bar_mask(32'(cnt_d)));
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mode_q <= ROTATE_L;
      dir_q  <= DIR_UP;
      pos_q  <= '0;
      cnt_q  <= '0;
      led_q  <= SEED;
      stb_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      dir_q  <= dir_d;
      pos_q  <= pos_d;
      cnt_q  <= cnt_d;
      led_q  <= led_d;
      stb_q  <= stb_d;
    end
  end
`ifdef LED_SEQ_PWM_EN
  logic [PWM_WIDTH-1:0] pwm_q;
  logic [LED_COUNT-1:0] out_led_q;
  logic                 out_stb_q;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pwm_q     <= '0;
      out_led_q <= SEED;
      out_stb_q <= 1'b0;
    end else begin
      pwm_q     <= pwm_q + PWM_WIDTH'(1);
      out_led_q <= led_q & {LED_COUNT{pwm_q < i_duty}};
      out_stb_q <= stb_q;
    end
  end
  assign o_led = out_led_q;
  assign o_stb = out_stb_q;
`else
  assign o_led = led_q;
  assign o_stb = stb_q;
`endif
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: scoreboard bench; a sequence-index reference model predicts o_led/o_stb every cycle.
module tb_led_sequencer;
  localparam int N = 4;
  localparam int PERIOD = 4;
  localparam logic [N-1:0] SEED = 4'b0001;
  logic clk = 1'b0;
  logic reset = 1'b1, run = 1'b0, step = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [N-1:0] led;
  logic stb;
  int checks = 0, passes = 0, cyc = 0;
  int m_ctr = 0, m_mode = 0, m_k = 0;
  bit m_stb = 1'b0, m_ostb = 1'b0;
  logic [N:0] exp_q[$];

  led_sequencer #(.COUNTER_WIDTH(2), .LED_COUNT(N), .SEED(SEED)) dut (
    .i_clk(clk), .i_reset(reset), .i_run(run), .i_step(step), .i_mode(mode),
    .o_led(led), .o_stb(stb)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] pattern(input int md, input int k);
    logic [2*N-1:0] tmp;
    int p;
    tmp = {SEED, SEED};
    case (md)
      0: begin tmp = tmp << (k % N); return tmp[2*N-1:N]; end
      1: begin tmp = tmp >> (k % N); return tmp[N-1:0]; end
      2: begin p = k % (2*N-2); return N'(1 << ((p < N) ? p : 2*N-2-p)); end
      default: return N'((1 << (k % (N+1))) - 1);
    endcase
  endfunction

  task automatic model_step();
    bit adv;
    if (reset) begin
      m_ctr = 0; m_stb = 0; m_mode = 0; m_k = 0; m_ostb = 0;
    end else begin
      adv = m_stb | step;
      if (int'(mode) != m_mode) begin
        m_mode = int'(mode); m_k = 0; m_ctr = 0; m_stb = 0; m_ostb = 0;
      end else begin
        m_ostb = adv;
        if (adv) m_k++;
        if (run) begin
          m_ctr++;
          m_stb = (m_ctr == PERIOD);
          if (m_stb) m_ctr = 0;
        end else m_stb = 0;
      end
    end
  endtask

  task automatic drive(input logic r, input logic ru, input logic st, input logic [1:0] md);
    @(negedge clk);
    reset = r; run = ru; step = st; mode = md;
    model_step();
    exp_q.push_back({pattern(m_mode, m_k), m_ostb});
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        logic [N:0] e;
        e = exp_q.pop_front();
        checks++;
        if ({led, stb} === e) passes++;
        else $display("FAIL cycle %0d led/stb got %b/%b expected %b/%b", cyc, led, stb, e[N:1], e[0]);
      end
    end
  end

  initial begin
    logic [1:0] md;
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    repeat (20) drive(0, 1, 0, 0);
    repeat (20) drive(0, 1, 0, 1);
    repeat (30) drive(0, 1, 0, 2);
    repeat (24) drive(0, 1, 0, 3);
    repeat (20) drive(0, 0, 0, 3);
    repeat (3) begin
      drive(0, 0, 1, 3);
      repeat (2) drive(0, 0, 0, 3);
    end
    repeat (8) drive(0, 1, m_stb, 0);
    repeat (8) drive(0, 1, m_stb, 0);
    for (int i = 0; i < 8 && !m_stb; i++) drive(0, 1, 0, 0);
    drive(0, 1, 0, 1);
    repeat (6) drive(0, 1, 0, 1);
    drive(0, 1, 0, 2);
    for (int i = 0; i < 40 && !(m_mode == 2 && (m_k % 6) == 4); i++) drive(0, 1, 0, 2);
    drive(1, 1, 0, 2);
    repeat (10) drive(0, 1, 0, 0);
    md = 2'd0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(15) == 0) md = 2'($urandom_range(3));
      drive($urandom_range(63) == 0, $urandom_range(7) != 0, $urandom_range(7) == 0, md);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain pending %0d expected 0", exp_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Parametrised LED pattern engine; successor to the single-mode rotating-LED shifter.
- A free-running prescaler generates an advance strobe. A small FSM drives an LED_COUNT-wide pattern in one of four selectable modes.
- Adds run/pause, single-step, live mode switching, a strobe output, and synchronous reset.
- Sits directly behind board LED pins; i_mode and i_run come from switches or a debounced-button block.

Parameters:
- COUNTER_WIDTH, 25, prescaler width; free-running strobe period = 2^COUNTER_WIDTH cycles.
- LED_COUNT, 4, number of LEDs; legal range 2..32.
- SEED, 1 (LED_COUNT bits), initial pattern for the rotate modes; must be nonzero.

Ports:
- i_clk  input  1  sole clock; all logic on posedge.
- i_reset  input  1  synchronous, active-high reset.
- i_run  input  1  1 = prescaler counts; 0 = prescaler holds, no free-running strobes.
- i_step  input  1  one-cycle pulse; forces a single advance regardless of i_run.
- i_mode  input  2  0 ROTATE_L, 1 ROTATE_R, 2 BOUNCE, 3 BAR.
- o_led  output  LED_COUNT  current pattern, registered.
- o_stb  output  1  one-cycle pulse in the same cycle o_led shows a newly advanced value.

Behaviour:
- Reset (sync, high) values:
  - prescaler = 0, stb = 0, o_stb = 0.
  - mode_q = ROTATE_L, o_led = SEED.
  - bounce pos = 0, dir = up; bar count = 0.
- Prescaler: {stb, counter} <= counter + 1 while i_run = 1. stb is the registered carry, high for one cycle every 2^COUNTER_WIDTH cycles. i_run = 0 holds counter and forces stb = 0. Resuming continues from the held count.
- Advance event adv = stb | i_step, evaluated combinationally in cycle t. The new o_led value and o_stb = 1 appear at edge t+1.
- ROTATE_L: o_led <= {o_led[N-2:0], o_led[N-1]}.
- ROTATE_R: o_led <= {o_led[0], o_led[N-1:1]}.
- BOUNCE: one-hot at pos.
  - dir up: pos+1; at pos N-1, flip to down and go to N-2.
  - dir down: pos-1; at pos 0, flip to up and go to 1.
  - No end LED is shown twice in a row. Period 2N-2.
- BAR: count 0..N; o_led = (1<<count)-1; after count = N (all on), the next adv gives count = 0 (all off). Period N+1.
- Mode change: mode_q != i_mode in cycle t → at edge t+1:
  - mode_q <= i_mode, prescaler cleared.
  - Pattern reloads to the mode seed: SEED for rotates, pos 0/up for BOUNCE (o_led = 1), count 0 for BAR (o_led = 0).
  - o_stb stays 0.
- Simultaneous mode change and adv: reload wins; the advance is dropped.
- i_step while i_run = 1: step advances once; a coincident stb is merged, giving one advance only.
- Reset mid-operation: overrides everything that cycle; all state returns to reset values.
- Width rules: count is $clog2(LED_COUNT+1) bits; pos is $clog2(LED_COUNT) bits. No truncation warnings are tolerated.

Optional Feature:
- Macro: LED_SEQ_PWM_EN.
- Defined:
  - Adds parameter PWM_WIDTH (default 4) and input i_duty[PWM_WIDTH-1:0].
  - A free-running pwm_cnt (reset 0) runs alongside the prescaler.
  - o_led = pattern & {N{pwm_cnt < i_duty}}, registered (one extra cycle of latency on o_led; o_stb delayed to match).
  - i_duty = 0 gives LEDs always off; all-ones gives (2^W-1)/2^W on-time.
- Undefined: no i_duty port and no PWM logic; o_led is the pattern register directly.

Decomposition:
- Package led_seq_pkg holds:
  - mode enum typedef led_mode_t (ROTATE_L/ROTATE_R/BOUNCE/BAR, 2 bits).
  - BOUNCE direction encodings.
  - Helper function for BAR mask generation.
- One sub-module: led_strobe_gen (COUNTER_WIDTH prescaler with run enable and sync clear, outputs stb). Pattern FSM stays in led_sequencer.

Test Plan (COUNTER_WIDTH=2, LED_COUNT=4, SEED=4'b0001, PWM off):
- Reset, i_run=1, mode 0 → o_led 0001, then 0010, 0100, 1000, 0001; one update every 4 cycles, o_stb high exactly in update cycles.
- Mode 1 from reset → 0001, 1000, 0100, 0010, 0001; mode-switch cycle shows reload to SEED with o_stb = 0.
- Mode 2 → 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010 (period 6, no repeated end value).
- Mode 3 → 0000, 0001, 0011, 0111, 1111, 0000.
- i_run=0 for 20 cycles → o_led constant, o_stb = 0; three i_step pulses → exactly three advances. i_step coincident with stb → single advance. Mode change coincident with stb → reload only.
- Assert i_reset mid-BOUNCE at pos 2/down → next cycle o_led = SEED, mode ROTATE_L, prescaler 0. With LED_SEQ_PWM_EN and i_duty=4 → LEDs on 4 of every 16 cycles; i_duty=0 → o_led all zero.
